shift_iter_unit: RTL
====================

SHIFT_ITER_UNIT -- requirements
Module: shift_iter_unit

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and the shift-amount field at 5 bits.
REQ-002 The block SHALL provide port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 The block SHALL provide port start  input  1  request pulse; sampled on the rising edge of clk.
REQ-005 The block SHALL provide port op  input  2  shift type: 00 sll, 01 srl, 11 sra, 10 reserved (executes as sll).
REQ-006 The block SHALL provide port data_in  input  32  operand to be shifted.
REQ-007 The block SHALL provide port amt  input  32  zero-extended shift amount; only amt[4:0] is used, and amt[31:5] is ignored.
REQ-008 The block SHALL provide port result  output  32  shifted value, registered.
REQ-009 The block SHALL provide port busy  output  1  high while a shift is in progress.
REQ-010 The block SHALL provide port done  output  1  one-cycle pulse marking result valid.

Function
REQ-011 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-012 In IDLE or DONE, start=1 SHALL be accepted: the block latches op, data_in and amt[4:0]; loads the working register with data_in; captures the fill bit (data_in[31] for sra, 0 otherwise); clears the step counter to 0; and enters RUN.
REQ-013 In RUN, each clock edge SHALL process step k (k = counter value 0..4): if latched amt[k]=1, the working register is shifted by 2^k in the latched direction, with vacated bits filled by the captured fill bit (left shifts fill with 0); the counter then increments.
REQ-014 After step 4, the block SHALL copy the working register to result, enter DONE, and assert done.
REQ-015 Latency SHALL be fixed: if start is sampled at edge E0, busy is high after E0 through E5, and done is high for exactly the cycle following E5, independent of the amount.
REQ-016 busy SHALL be 1 exactly when the state is RUN.
REQ-017 done SHALL be 1 exactly when the state is DONE; DONE SHALL last one cycle and then return to IDLE unless a start is accepted.
REQ-018 start=1 during RUN SHALL be ignored, with no effect on the latched operands or timing.
REQ-019 start=1 in the DONE cycle SHALL be accepted (back-to-back operation), so done is a single-cycle pulse and busy rises on the next cycle.
REQ-020 result SHALL hold its last value in IDLE, RUN and DONE and change only at the REQ-014 update; changes on data_in, amt or op after acceptance SHALL NOT affect the operation in flight.
REQ-021 amt[4:0]=0 SHALL still take 5 RUN cycles and produce result = data_in.
REQ-022 amt[4:0]=31 SHALL produce the correct 31-bit shift; sra SHALL replicate the original sign bit across all vacated positions.
REQ-023 Arithmetic SHALL be purely logical bit movement, with no overflow or exception signalling.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force state=IDLE, counter=0, result=32'h0000_0000, busy=0 and done=0, regardless of the clock.
REQ-025 Reset during RUN SHALL abort the operation with no done pulse; after rst_n returns to 1, the first start SHALL behave per REQ-015.
REQ-026 start SHALL be ignored while rst_n=0.

Verification
REQ-027 The bench SHALL cover: op=00, data_in=32'h0000_0001, amt=32'h0000_0004 -> result=32'h0000_0010 with done high exactly 6 cycles after the start edge.
REQ-028 The bench SHALL cover: op=11, data_in=32'h8000_0000, amt=32'h0000_001F -> result=32'hFFFF_FFFF; the same stimulus with op=01 -> result=32'h0000_0001.
REQ-029 The bench SHALL cover: op=01, data_in=32'hDEAD_BEEF, amt=32'hFFFF_FFE0 (low 5 bits 0) -> result=32'hDEAD_BEEF after the full 5-cycle run.
REQ-030 The bench SHALL cover: start re-asserted with new operands at cycle 2 of RUN -> ignored, original result delivered; start asserted in the DONE cycle -> second operation accepted, and its done arrives 6 cycles later.
REQ-031 The bench SHALL cover: rst_n pulled low at cycle 3 of RUN -> busy=0, done=0 and result=0 asynchronously, with no done pulse afterwards until a new start.
REQ-032 The bench SHALL cover: op=10, data_in=32'h0000_00FF, amt=8 -> result=32'h0000_FF00 (executes as sll).

Source files
------------

// File: rtl/shift_iter_unit.sv
// Iterative barrel shifter: one binary-weighted shift stage per clock (1, 2, 4, 8, 16).
// Fixed five-cycle run regardless of the amount, then a one-cycle done pulse.
module shift_iter_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] data_in,
    input  logic [31:0] amt,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic [4:0]         amt_q, amt_d;
    logic [31:0]        work_q, work_d;
    logic               fill_q, fill_d;
    logic               right_q, right_d;
    logic [31:0]        result_q, result_d;

    logic [4:0]         step_sh;
    logic signed [32:0] ext_val;
    logic signed [32:0] right_val;
    logic [31:0]        left_val;
    logic [31:0]        step_val;
    logic               step_en;

    // Only the low five amount bits select a shift.
    logic unused_amt;
    assign unused_amt = ^amt[31:5];

    // Fill bit rides in bit 32 so an arithmetic shift replicates it into vacated positions.
    always_comb begin
        step_sh   = 5'd1 << cnt_q;
        ext_val   = {fill_q, work_q};
        right_val = ext_val >>> step_sh;
        left_val  = work_q << step_sh;
        step_en   = 1'b0;
        unique case (cnt_q)
            3'd0:    step_en = amt_q[0];
            3'd1:    step_en = amt_q[1];
            3'd2:    step_en = amt_q[2];
            3'd3:    step_en = amt_q[3];
            3'd4:    step_en = amt_q[4];
            default: step_en = 1'b0;
        endcase
        if (step_en) begin
            step_val = right_q ? right_val[31:0] : left_val;
        end else begin
            step_val = work_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        amt_d    = amt_q;
        work_d   = work_q;
        fill_d   = fill_q;
        right_d  = right_q;
        result_d = result_q;
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    amt_d   = amt[4:0];
                    work_d  = data_in;
                    // op 10 is reserved and executes as a left shift.
                    right_d = op[0];
                    fill_d  = (op == 2'b11) & data_in[31];
                    cnt_d   = 3'd0;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                work_d = step_val;
                if (cnt_q == 3'd4) begin
                    result_d = step_val;
                    cnt_d    = 3'd0;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 3'd0;
            amt_q    <= 5'd0;
            work_q   <= 32'h0000_0000;
            fill_q   <= 1'b0;
            right_q  <= 1'b0;
            result_q <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            amt_q    <= amt_d;
            work_q   <= work_d;
            fill_q   <= fill_d;
            right_q  <= right_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;
    assign busy   = (state_q == StRun);
    assign done   = (state_q == StDone);

endmodule
